// File: rtl/sc_mult_unit.sv
// ----------------------------------------------------------------------------
// sc_mult_unit
// Stochastic-computing multiplier. Two maximal-length Fibonacci LFSRs turn the
// latched operands into bitstreams by a >= comparison, the per-cycle product
// bit (AND unipolar, XNOR bipolar) is counted over one full LFSR period of
// L = 2**WIDTH-1 cycles, and the ones-count is returned with a done pulse.
//
// Optional build macro: SC_STREAM_OUT_EN adds registered copies of the
// per-cycle stream bits (sa_o, sb_o, p_o) plus a stream_vld qualifier.
// ----------------------------------------------------------------------------
module sc_mult_unit #(
    parameter int unsigned      WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS_A = 8'h8E,
    parameter logic [WIDTH-1:0] TAPS_B = 8'hB8,
    parameter logic [WIDTH-1:0] SEED_A = 8'd1,
    parameter logic [WIDTH-1:0] SEED_B = 8'd244
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef SC_STREAM_OUT_EN
    ,
    output logic             sa_o,
    output logic             sb_o,
    output logic             p_o,
    output logic             stream_vld
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Step index of the L-th (final) RUN edge: L-1 = 2**WIDTH-2.
    localparam logic [WIDTH-1:0] LAST_STEP = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic [WIDTH-1:0] r_lfsr_a;
    logic [WIDTH-1:0] r_lfsr_b;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_step;
    logic             r_done;
    logic [WIDTH-1:0] r_result;

    logic             w_sa;
    logic             w_sb;
    logic             w_p;
    logic             w_fb_a;
    logic             w_fb_b;
    logic [WIDTH-1:0] w_count_nxt;

    // Per-cycle stream bits, product bit and LFSR feedback for the current state.
    always_comb begin
        w_sa        = (r_a >= r_lfsr_a);
        w_sb        = (r_b >= r_lfsr_b);
        w_p         = r_mode ? ~(w_sa ^ w_sb) : (w_sa & w_sb);
        w_fb_a      = ^(r_lfsr_a & TAPS_A);
        w_fb_b      = ^(r_lfsr_b & TAPS_B);
        // Count never exceeds L, so no overflow handling is required.
        w_count_nxt = r_count + WIDTH'(w_p);
    end

    // Control FSM plus operand latches, LFSRs and ones-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_lfsr_a <= SEED_A;
            r_lfsr_b <= SEED_B;
            r_count  <= '0;
            r_step   <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_mode   <= mode;
                        r_lfsr_a <= SEED_A;
                        r_lfsr_b <= SEED_B;
                        r_count  <= '0;
                        r_step   <= '0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_count  <= w_count_nxt;
                    r_lfsr_a <= {r_lfsr_a[WIDTH-2:0], w_fb_a};
                    r_lfsr_b <= {r_lfsr_b[WIDTH-2:0], w_fb_b};
                    r_step   <= r_step + WIDTH'(1);
                    if (r_step == LAST_STEP) begin
                        r_result <= w_count_nxt;
                        r_done   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == ST_RUN);
    assign done   = r_done;
    assign result = r_result;

`ifdef SC_STREAM_OUT_EN
    logic r_sa;
    logic r_sb;
    logic r_p;
    logic r_stream_vld;

    // Registered copies of the stream bits from every RUN edge; vld marks them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_p          <= 1'b0;
            r_stream_vld <= 1'b0;
        end else begin
            r_stream_vld <= (r_state == ST_RUN);
            if (r_state == ST_RUN) begin
                r_sa <= w_sa;
                r_sb <= w_sb;
                r_p  <= w_p;
            end else begin
                r_sa <= 1'b0;
                r_sb <= 1'b0;
                r_p  <= 1'b0;
            end
        end
    end

    assign sa_o       = r_sa;
    assign sb_o       = r_sb;
    assign p_o        = r_p;
    assign stream_vld = r_stream_vld;
`endif

endmodule
